mem_arb_rr2: RTL

- Two-requester round-robin arbiter and sequencer for one single-port RAM (memory_para: write on clk edge, combinational read).
- Each requester gets a valid/ready request channel and a registered read-response channel.
- Supports locked sequences, so one requester can hold the RAM for back-to-back accesses (e.g. read-modify-write).
- Sits between the RAM instance and two masters, e.g. a DMA engine and a CPU port.

---
 rtl/mem_arb_rr2.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_arb_rr2.sv
// Two-requester round-robin arbiter/sequencer for one single-port RAM with locked sequences.
// Define MEM_ARB_PERF_EN to add saturating per-requester accept counters (gnt_cnt0/gnt_cnt1).
module mem_arb_rr2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic                  req0_lock,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic                  req1_lock,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [1:0]            dbg_state
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  gnt_cnt0,
    output logic [CNT_WIDTH-1:0]  gnt_cnt1
`endif
);

    // Handshake: a request transfers in the cycle where reqN_valid and reqN_ready are both 1;
    // ready is combinational, never depends on itself, and is never high for both requesters.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  prio;
    logic                  prio_nxt;
    logic                  acc0;
    logic                  acc1;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;

    assign dbg_state  = state;
    assign req0_ready = acc0;
    assign req1_ready = acc1;

    always_comb begin
        acc0      = 1'b0;
        acc1      = 1'b0;
        state_nxt = state;
        prio_nxt  = prio;
        case (state)
            IDLE: begin
                acc0 = req0_valid & (~req1_valid | ~prio);
                acc1 = req1_valid & (~req0_valid | prio);
            end
            LOCK0:   acc0 = req0_valid;
            LOCK1:   acc1 = req1_valid;
            default: ;
        endcase

        if (acc0) begin
            state_nxt = req0_lock ? LOCK0 : IDLE;
            if (!req0_lock) prio_nxt = 1'b1;
        end else if (acc1) begin
            state_nxt = req1_lock ? LOCK1 : IDLE;
            if (!req1_lock) prio_nxt = 1'b0;
        end
    end

    // With no accept the address/data buses park on the last granted values.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_din  = din_q;
        if (acc0) begin
            mem_we   = req0_we;
            mem_addr = req0_addr;
            mem_din  = req0_wdata;
        end else if (acc1) begin
            mem_we   = req1_we;
            mem_addr = req1_addr;
            mem_din  = req1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state      <= state_nxt;
            prio       <= prio_nxt;
            rsp0_valid <= acc0 & ~req0_we;
            rsp1_valid <= acc1 & ~req1_we;
            if (acc0 & ~req0_we) rsp0_rdata <= mem_dout;
            if (acc1 & ~req1_we) rsp1_rdata <= mem_dout;
            if (acc0 | acc1) begin
                addr_q <= mem_addr;
                din_q  <= mem_din;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (acc0 && gnt_cnt0 != CNT_MAX) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (acc1 && gnt_cnt1 != CNT_MAX) gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end
`else
    // CNT_WIDTH only sizes the counters; this empty block keeps it referenced in the lean build.
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

endmodule
